// File: rtl/io_peripheral.sv
// io_peripheral: CPU-facing IO port bridging a host input stream (through a
// small FIFO read by CPU IO-read strobes) and a single-word output holding
// register handed to the host with a valid/ready handshake.
module io_peripheral #(
   parameter int DEPTH  = 4,
   parameter int DATA_W = 32
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              inctrl,
   input  logic              outctrl,
   input  logic [DATA_W-1:0] cpuWord,
   output logic [DATA_W-1:0] devWord,
   input  logic [DATA_W-1:0] hostInData,
   input  logic              hostInValid,
   output logic              hostInReady,
   output logic [DATA_W-1:0] hostOutData,
   output logic              hostOutValid,
   input  logic              hostOutReady,
   output logic              inEmpty,
   output logic              underflow,
   output logic              overrun
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AW:0]   DEPTH_C = (AW+1)'(DEPTH);
   localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
   localparam logic [AW-1:0] PTR_ONE = AW'(1);

   typedef enum logic {IDLE, HOLD} out_state_t;

   // FIFO storage and bookkeeping
   logic [DATA_W-1:0] mem [DEPTH];
   logic [AW-1:0]     wptr_reg;
   logic [AW-1:0]     rptr_reg;
   logic [AW:0]       count_reg;

   // Strobe history for edge detection
   logic inctrl_d_reg;
   logic outctrl_d_reg;

   // Output channel
   out_state_t        state_reg;
   logic              hostout_valid_reg;
   logic [DATA_W-1:0] hostout_data_reg;

   logic underflow_reg;
   logic overrun_reg;

   logic read_ev;
   logic write_ev;
   logic push;
   logic pop;
   logic fifo_empty;

   assign fifo_empty = (count_reg == '0);
   assign read_ev    = inctrl & ~inctrl_d_reg;
   // A write strobe rising while a read strobe is high is dropped outright;
   // the delay register still tracks outctrl so it cannot fire later.
   assign write_ev   = outctrl & ~outctrl_d_reg & ~inctrl;
   assign push       = hostInValid & hostInReady;
   // A read on an empty FIFO never pops, even if a word lands the same cycle.
   assign pop        = read_ev & ~fifo_empty;

   assign hostInReady  = (count_reg < DEPTH_C);
   assign devWord      = fifo_empty ? '0 : mem[rptr_reg];
   assign inEmpty      = fifo_empty;
   assign hostOutValid = hostout_valid_reg;
   assign hostOutData  = hostout_data_reg;
   assign underflow    = underflow_reg;
   assign overrun      = overrun_reg;

   // Remember previous strobe levels; cleared on reset so a strobe held
   // high through reset release is seen as an edge on the first cycle.
   always_ff @(posedge clock) begin
      if (reset) begin
         inctrl_d_reg  <= 1'b0;
         outctrl_d_reg <= 1'b0;
      end else begin
         inctrl_d_reg  <= inctrl;
         outctrl_d_reg <= outctrl;
      end
   end

   // FIFO data array write; no reset so it maps onto plain storage.
   always_ff @(posedge clock) begin
      if (push && !reset) begin
         mem[wptr_reg] <= hostInData;
      end
   end

   // FIFO pointers, occupancy and the sticky underflow flag.
   always_ff @(posedge clock) begin
      if (reset) begin
         wptr_reg      <= '0;
         rptr_reg      <= '0;
         count_reg     <= '0;
         underflow_reg <= 1'b0;
      end else begin
         if (push) begin
            wptr_reg <= wptr_reg + PTR_ONE;
         end
         if (pop) begin
            rptr_reg <= rptr_reg + PTR_ONE;
         end
         case ({push, pop})
            2'b10:   count_reg <= count_reg + CNT_ONE;
            2'b01:   count_reg <= count_reg - CNT_ONE;
            default: count_reg <= count_reg;
         endcase
         if (read_ev && fifo_empty) begin
            underflow_reg <= 1'b1;
         end
      end
   end

   // Output channel FSM: IDLE waits for a CPU write, HOLD presents the word
   // until the host takes it; a write the host has not made room for is lost.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_reg         <= IDLE;
         hostout_valid_reg <= 1'b0;
         hostout_data_reg  <= '0;
         overrun_reg       <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (write_ev) begin
                  hostout_data_reg  <= cpuWord;
                  state_reg         <= HOLD;
                  hostout_valid_reg <= 1'b1;
               end
            end
            HOLD: begin
               if (hostOutReady) begin
                  if (write_ev) begin
                     hostout_data_reg <= cpuWord;
                  end else begin
                     state_reg         <= IDLE;
                     hostout_valid_reg <= 1'b0;
                  end
               end else if (write_ev) begin
                  overrun_reg <= 1'b1;
               end
            end
            default: begin
               state_reg         <= IDLE;
               hostout_valid_reg <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_io_peripheral.sv
// Testbench for io_peripheral: directed vectors, scoreboard queues for words
// read by the CPU and words accepted by the host, plus direct status checks.
module tb_io_peripheral;

   logic        clock;
   logic        reset;
   logic        inctrl;
   logic        outctrl;
   logic [31:0] cpuWord;
   logic [31:0] devWord;
   logic [31:0] hostInData;
   logic        hostInValid;
   logic        hostInReady;
   logic [31:0] hostOutData;
   logic        hostOutValid;
   logic        hostOutReady;
   logic        inEmpty;
   logic        underflow;
   logic        overrun;

   int checks = 0;
   int errors = 0;

   logic [31:0] exp_dev[$];
   logic [31:0] exp_host[$];

   io_peripheral #(.DEPTH(4), .DATA_W(32)) dut (
      .clock        (clock),
      .reset        (reset),
      .inctrl       (inctrl),
      .outctrl      (outctrl),
      .cpuWord      (cpuWord),
      .devWord      (devWord),
      .hostInData   (hostInData),
      .hostInValid  (hostInValid),
      .hostInReady  (hostInReady),
      .hostOutData  (hostOutData),
      .hostOutValid (hostOutValid),
      .hostOutReady (hostOutReady),
      .inEmpty      (inEmpty),
      .underflow    (underflow),
      .overrun      (overrun)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end else begin
         $display("ok   %s: 0x%08h", name, act);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic wr_fifo(input logic [31:0] w);
      hostInData  = w;
      hostInValid = 1'b1;
      step();
      hostInValid = 1'b0;
   endtask

   task automatic rd(input logic [31:0] e);
      exp_dev.push_back(e);
      inctrl = 1'b1;
      step();
      inctrl = 1'b0;
      step();
   endtask

   task automatic cw(input logic [31:0] w);
      cpuWord = w;
      outctrl = 1'b1;
      step();
      outctrl = 1'b0;
      step();
   endtask

   // Monitor: compares devWord on every CPU read edge and hostOutData on
   // every host handshake against the scoreboard queues.
   initial begin : monitor
      logic        prev_in;
      logic [31:0] e;
      prev_in = 1'b0;
      forever begin
         @(negedge clock);
         if (!reset && inctrl && !prev_in) begin
            if (exp_dev.size() == 0) begin
               chk("dev_read_unexpected", devWord, 32'hFFFF_FFFF);
            end else begin
               e = exp_dev.pop_front();
               chk("dev_read_word", devWord, e);
            end
         end
         if (!reset && hostOutValid && hostOutReady) begin
            if (exp_host.size() == 0) begin
               chk("host_accept_unexpected", hostOutData, 32'hFFFF_FFFF);
            end else begin
               e = exp_host.pop_front();
               chk("host_accept_word", hostOutData, e);
            end
         end
         prev_in = reset ? 1'b0 : inctrl;
      end
   end

   initial begin : stimulus
      reset        = 1'b1;
      inctrl       = 1'b0;
      outctrl      = 1'b0;
      cpuWord      = '0;
      hostInData   = '0;
      hostInValid  = 1'b0;
      hostOutReady = 1'b0;
      step();
      step();
      chk("rst_devWord", devWord, 32'h0);
      chk("rst_hostInReady", {31'b0, hostInReady}, 32'h1);
      chk("rst_hostOutValid", {31'b0, hostOutValid}, 32'h0);
      chk("rst_inEmpty", {31'b0, inEmpty}, 32'h1);
      chk("rst_flags", {30'b0, underflow, overrun}, 32'h0);
      reset = 1'b0;
      step();

      // Fill to DEPTH, fifth word must be refused
      wr_fifo(32'h11);
      wr_fifo(32'h22);
      wr_fifo(32'h33);
      wr_fifo(32'h44);
      chk("full_hostInReady", {31'b0, hostInReady}, 32'h0);
      hostInData  = 32'h55;
      hostInValid = 1'b1;
      step();
      hostInValid = 1'b0;
      chk("full_devWord_head", devWord, 32'h11);
      rd(32'h11);
      rd(32'h22);
      rd(32'h33);
      rd(32'h44);
      chk("drained_inEmpty", {31'b0, inEmpty}, 32'h1);
      chk("drained_devWord", devWord, 32'h0);

      // Held read strobe pops exactly once
      wr_fifo(32'h11);
      wr_fifo(32'h22);
      exp_dev.push_back(32'h11);
      inctrl = 1'b1;
      step();
      step();
      step();
      inctrl = 1'b0;
      step();
      chk("held_read_devWord", devWord, 32'h22);
      chk("held_read_not_empty", {31'b0, inEmpty}, 32'h0);
      chk("held_read_no_underflow", {31'b0, underflow}, 32'h0);
      rd(32'h22);
      chk("held_read_then_empty", {31'b0, inEmpty}, 32'h1);

      // Read on empty FIFO
      rd(32'h0);
      chk("empty_read_underflow", {31'b0, underflow}, 32'h1);
      chk("empty_read_inEmpty", {31'b0, inEmpty}, 32'h1);
      chk("empty_read_devWord", devWord, 32'h0);
      wr_fifo(32'h77);
      chk("after_underflow_devWord", devWord, 32'h77);
      rd(32'h77);

      // Simultaneous push and pop
      wr_fifo(32'hA1);
      exp_dev.push_back(32'hA1);
      hostInData  = 32'hA2;
      hostInValid = 1'b1;
      inctrl      = 1'b1;
      step();
      hostInValid = 1'b0;
      inctrl      = 1'b0;
      step();
      chk("pushpop_devWord", devWord, 32'hA2);
      chk("pushpop_not_empty", {31'b0, inEmpty}, 32'h0);
      rd(32'hA2);
      chk("pushpop_then_empty", {31'b0, inEmpty}, 32'h1);

      // Output channel with host stalled, then overrun
      hostOutReady = 1'b0;
      cw(32'hDEADBEEF);
      chk("hold_valid", {31'b0, hostOutValid}, 32'h1);
      chk("hold_data", hostOutData, 32'hDEADBEEF);
      chk("hold_no_overrun", {31'b0, overrun}, 32'h0);
      cw(32'h12345678);
      chk("overrun_flag", {31'b0, overrun}, 32'h1);
      chk("overrun_data_kept", hostOutData, 32'hDEADBEEF);
      chk("overrun_valid", {31'b0, hostOutValid}, 32'h1);
      exp_host.push_back(32'hDEADBEEF);
      hostOutReady = 1'b1;
      step();
      hostOutReady = 1'b0;
      chk("accepted_valid_low", {31'b0, hostOutValid}, 32'h0);
      chk("accepted_data_kept", hostOutData, 32'hDEADBEEF);

      // Write edge during a read strobe is dropped, not deferred
      cpuWord = 32'hBAD0BAD0;
      exp_dev.push_back(32'h0);
      inctrl  = 1'b1;
      outctrl = 1'b1;
      step();
      inctrl = 1'b0;
      step();
      outctrl = 1'b0;
      step();
      chk("ignored_write_valid", {31'b0, hostOutValid}, 32'h0);
      chk("ignored_write_data", hostOutData, 32'hDEADBEEF);

      // HOLD with ready and a simultaneous write replaces the word
      cw(32'h0000AAAA);
      chk("hold2_valid", {31'b0, hostOutValid}, 32'h1);
      exp_host.push_back(32'h0000AAAA);
      exp_host.push_back(32'hCAFE0001);
      cpuWord      = 32'hCAFE0001;
      outctrl      = 1'b1;
      hostOutReady = 1'b1;
      step();
      outctrl = 1'b0;
      chk("replace_valid", {31'b0, hostOutValid}, 32'h1);
      chk("replace_data", hostOutData, 32'hCAFE0001);
      step();
      hostOutReady = 1'b0;
      chk("replace_then_idle", {31'b0, hostOutValid}, 32'h0);
      chk("replace_data_kept", hostOutData, 32'hCAFE0001);

      // Reset with FIFO occupied and channel in HOLD
      wr_fifo(32'h1);
      wr_fifo(32'h2);
      wr_fifo(32'h3);
      cw(32'h99);
      chk("prereset_valid", {31'b0, hostOutValid}, 32'h1);
      reset  = 1'b1;
      inctrl = 1'b1;
      step();
      chk("reset_inEmpty", {31'b0, inEmpty}, 32'h1);
      chk("reset_hostInReady", {31'b0, hostInReady}, 32'h1);
      chk("reset_hostOutValid", {31'b0, hostOutValid}, 32'h0);
      chk("reset_flags", {30'b0, underflow, overrun}, 32'h0);
      chk("reset_devWord", devWord, 32'h0);
      chk("reset_hostOutData", hostOutData, 32'h0);
      // inctrl held high across release counts as an edge on empty FIFO
      reset = 1'b0;
      exp_dev.push_back(32'h0);
      step();
      inctrl = 1'b0;
      chk("release_edge_underflow", {31'b0, underflow}, 32'h1);

      // Push into empty FIFO coinciding with a read edge
      reset = 1'b1;
      step();
      reset = 1'b0;
      step();
      exp_dev.push_back(32'h0);
      hostInData  = 32'h5A;
      hostInValid = 1'b1;
      inctrl      = 1'b1;
      step();
      hostInValid = 1'b0;
      inctrl      = 1'b0;
      step();
      chk("push_on_empty_read_underflow", {31'b0, underflow}, 32'h1);
      chk("push_on_empty_read_stored", {31'b0, inEmpty}, 32'h0);
      chk("push_on_empty_read_devWord", devWord, 32'h5A);
      rd(32'h5A);

      step();
      chk("dev_queue_drained", exp_dev.size(), 32'h0);
      chk("host_queue_drained", exp_host.size(), 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
